// File: rtl/debug_run_controller_pkg.sv
// rtl/debug_run_controller_pkg.sv - command codes, state encodings and halt opcode for the debug run controller
package debug_run_controller_pkg;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_RUN  = 3'd1;
    localparam logic [2:0] CMD_STEP = 3'd2;
    localparam logic [2:0] CMD_HALT = 3'd3;
    localparam logic [2:0] CMD_PRST = 3'd4;

    // Shared with the assembler and the SPI debug unit.
    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_PRST  = 3'd5
    } state_t;

    function automatic logic enables_pipe(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/debug_run_controller_sat_counter.sv
// rtl/debug_run_controller_sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_count <= '0;
        end else if (i_en && (o_count != {W{1'b1}})) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/debug_run_controller.sv
// rtl/debug_run_controller.sv - debug-mode pipeline sequencer: run, step, halt drain and pipeline reset
module debug_run_controller
    import debug_run_controller_pkg::*;
#(
    parameter int                   NB_BITS      = 32,
    parameter int                   NB_STEP      = 16,
    parameter int                   NB_CYC       = 32,
    parameter int                   DRAIN_CYCLES = 4,
    parameter int                   PRST_CYCLES  = 2,
    parameter logic [NB_BITS-1:0]   HALT_INSTR   = NB_BITS'(HALT_OPCODE)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    input  logic [2:0]         i_cmd,
    input  logic [NB_STEP-1:0] i_step_count,
    input  logic [NB_BITS-1:0] i_if_id_instr,
    output logic               o_cmd_ready,
    output logic               o_debug_enb,
    output logic               o_pipe_rst,
    output logic               o_halted,
    output logic [2:0]         o_state,
    output logic [NB_CYC-1:0]  o_run_cycles
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int PW = $clog2(PRST_CYCLES + 1);

    state_t             state, state_n;
    logic [NB_STEP-1:0] step_cnt, step_n;
    logic [DW-1:0]      drain_cnt, drain_n;
    logic [PW-1:0]      prst_cnt, prst_n;
    logic               accept, halt_hit, clr_cycles;

    assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
    assign o_state     = state;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign halt_hit    = o_debug_enb && (i_if_id_instr == HALT_INSTR);
    assign clr_cycles  = (state_n == ST_PRST) && (state != ST_PRST);

    always_comb begin
        state_n = state;
        step_n  = step_cnt;
        drain_n = drain_cnt;
        prst_n  = prst_cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_RUN:  state_n = ST_RUN;
                        CMD_STEP: begin
                            state_n = ST_STEP;
                            step_n  = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;
                        end
                        CMD_PRST: begin
                            state_n = ST_PRST;
                            prst_n  = PW'(PRST_CYCLES);
                        end
                        default: ;
                    endcase
                end
            end
            // A HALT opcode reaching IF/ID wins over a host halt or step expiry on the same edge.
            ST_RUN: begin
                if (halt_hit) begin
                    state_n = ST_DRAIN;
                    drain_n = DW'(DRAIN_CYCLES);
                end else if (accept && (i_cmd == CMD_HALT)) begin
                    state_n = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_hit) begin
                    state_n = ST_DRAIN;
                    drain_n = DW'(DRAIN_CYCLES);
                end else if (step_cnt == NB_STEP'(1)) begin
                    state_n = ST_IDLE;
                end else begin
                    step_n = step_cnt - NB_STEP'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(1)) state_n = ST_DONE;
                else                     drain_n = drain_cnt - DW'(1);
            end
            ST_PRST: begin
                if (prst_cnt == PW'(1)) state_n = ST_IDLE;
                else                    prst_n  = prst_cnt - PW'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            step_cnt    <= '0;
            drain_cnt   <= '0;
            prst_cnt    <= '0;
            o_debug_enb <= 1'b0;
            o_pipe_rst  <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            state       <= state_n;
            step_cnt    <= step_n;
            drain_cnt   <= drain_n;
            prst_cnt    <= prst_n;
            o_debug_enb <= enables_pipe(state_n);
            o_pipe_rst  <= (state_n == ST_PRST);
            o_halted    <= (state_n == ST_DONE);
        end
    end

    sat_counter #(.W(NB_CYC)) u_run_cycles (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (o_debug_enb),
        .i_clr   (clr_cycles),
        .o_count (o_run_cycles)
    );

endmodule

// File: tb/tb_debug_run_controller.sv
// tb/tb_debug_run_controller.sv - directed self-checking bench for debug_run_controller
module tb_debug_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [15:0] step_count = 16'd0;
    logic [31:0] instr = 32'h0000_0000;

    logic        cmd_ready, debug_enb, pipe_rst, halted;
    logic [2:0]  state;
    logic [31:0] run_cycles;
    logic        s_cmd_ready, s_debug_enb, s_pipe_rst, s_halted;
    logic [2:0]  s_state;
    logic [3:0]  s_run_cycles;

    int errors = 0;
    int checks = 0;
    logic [5:0] pat;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_I = 32'h0000_0000;

    always #5 clk = ~clk;

    debug_run_controller dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count), .i_if_id_instr(instr),
        .o_cmd_ready(cmd_ready), .o_debug_enb(debug_enb), .o_pipe_rst(pipe_rst),
        .o_halted(halted), .o_state(state), .o_run_cycles(run_cycles)
    );

    debug_run_controller #(.NB_CYC(4)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count), .i_if_id_instr(instr),
        .o_cmd_ready(s_cmd_ready), .o_debug_enb(s_debug_enb), .o_pipe_rst(s_pipe_rst),
        .o_halted(s_halted), .o_state(s_state), .o_run_cycles(s_run_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [15:0] n);
        cmd_valid  = 1'b1;
        cmd        = c;
        step_count = n;
        tick();
        cmd_valid  = 1'b0;
        cmd        = 3'd0;
        step_count = 16'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr = NOP_I;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        checks++; if (debug_enb !== 1'b0) begin errors++; $display("FAIL reset_enb: got %0d expected 0", debug_enb); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", cmd_ready); end
        checks++; if (run_cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", run_cycles); end
        checks++; if ({pipe_rst, halted} !== 2'b00) begin errors++; $display("FAIL reset_rst_halt: got %b expected 00", {pipe_rst, halted}); end
    endtask

    task automatic test_step3();
        send(3'd2, 16'd3);
        for (int i = 0; i < 6; i++) begin
            pat[i] = debug_enb;
            if (i == 0) begin
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL step_ready: got %0d expected 0", cmd_ready); end
            end
            tick();
        end
        checks++; if (pat !== 6'b000111) begin errors++; $display("FAIL step3_pattern: got %b expected 000111", pat); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL step3_state: got %0d expected 0", state); end
        checks++; if (run_cycles !== 32'd3) begin errors++; $display("FAIL step3_cycles: got %0d expected 3", run_cycles); end
    endtask

    task automatic test_step0();
        send(3'd2, 16'd0);
        for (int i = 0; i < 6; i++) begin
            pat[i] = debug_enb;
            tick();
        end
        checks++; if (pat !== 6'b000001) begin errors++; $display("FAIL step0_pattern: got %b expected 000001", pat); end
        checks++; if (run_cycles !== 32'd4) begin errors++; $display("FAIL step0_cycles: got %0d expected 4", run_cycles); end
    endtask

    task automatic test_halt_detect();
        do_reset();
        send(3'd1, 16'd0);
        checks++; if (debug_enb !== 1'b1) begin errors++; $display("FAIL run_latency: got %0d expected 1", debug_enb); end
        repeat (5) tick();
        instr = HALT;
        tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL drain_state: got %0d expected 3", state); end
        for (int i = 0; i < 5; i++) begin
            pat[i] = debug_enb;
            tick();
        end
        pat[5] = 1'b0;
        checks++; if (pat !== 6'b001111) begin errors++; $display("FAIL drain_pattern: got %b expected 001111", pat); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL done_state: got %0d expected 4", state); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL done_halted: got %0d expected 1", halted); end
        checks++; if (run_cycles !== 32'd10) begin errors++; $display("FAIL done_cycles: got %0d expected 10", run_cycles); end
        instr = NOP_I;
    endtask

    task automatic test_prst_from_done();
        send(3'd4, 16'd0);
        checks++; if ({pipe_rst, debug_enb} !== 2'b10) begin errors++; $display("FAIL prst_c1: got %b expected 10", {pipe_rst, debug_enb}); end
        checks++; if (run_cycles !== 32'd0) begin errors++; $display("FAIL prst_cycles: got %0d expected 0", run_cycles); end
        checks++; if ({halted, state} !== 4'b0_101) begin errors++; $display("FAIL prst_state: got %b expected 0101", {halted, state}); end
        tick();
        checks++; if ({pipe_rst, debug_enb} !== 2'b10) begin errors++; $display("FAIL prst_c2: got %b expected 10", {pipe_rst, debug_enb}); end
        tick();
        checks++; if ({pipe_rst, state} !== 4'b0_000) begin errors++; $display("FAIL prst_end: got %b expected 0000", {pipe_rst, state}); end
    endtask

    task automatic test_host_halt();
        send(3'd1, 16'd0);
        repeat (4) tick();
        cmd_valid = 1'b1;
        cmd = 3'd3;
        tick();
        cmd_valid = 1'b0;
        cmd = 3'd0;
        checks++; if ({debug_enb, halted, state} !== 5'b00_000) begin errors++; $display("FAIL host_halt: got %b expected 00000", {debug_enb, halted, state}); end
        checks++; if (run_cycles !== 32'd5) begin errors++; $display("FAIL host_halt_cycles: got %0d expected 5", run_cycles); end
        send(3'd2, 16'd2);
        repeat (3) tick();
        checks++; if (run_cycles !== 32'd7) begin errors++; $display("FAIL step2_cycles: got %0d expected 7", run_cycles); end
    endtask

    task automatic test_priority();
        do_reset();
        instr = HALT;
        send(3'd2, 16'd1);
        tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL prio_step: got %0d expected 3", state); end
        do_reset();
        send(3'd1, 16'd0);
        instr = HALT;
        cmd_valid = 1'b1;
        cmd = 3'd3;
        tick();
        cmd_valid = 1'b0;
        cmd = 3'd0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL prio_host: got %0d expected 3", state); end
        instr = NOP_I;
    endtask

    task automatic test_cmd_misc();
        do_reset();
        send(3'd7, 16'd0);
        checks++; if ({cmd_ready, debug_enb, state} !== 5'b10_000) begin errors++; $display("FAIL unknown_cmd: got %b expected 10000", {cmd_ready, debug_enb, state}); end
        send(3'd1, 16'd0);
        send(3'd2, 16'd5);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_drop_cmd: got %0d expected 1", state); end
    endtask

    task automatic test_rst_in_drain();
        do_reset();
        send(3'd1, 16'd0);
        instr = HALT;
        repeat (2) tick();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL pre_rst_drain: got %0d expected 3", state); end
        rst = 1'b1;
        tick();
        checks++; if ({debug_enb, pipe_rst, halted, cmd_ready, state} !== 7'b0001_000) begin errors++; $display("FAIL rst_drain_outs: got %b expected 0001000", {debug_enb, pipe_rst, halted, cmd_ready, state}); end
        checks++; if (run_cycles !== 32'd0) begin errors++; $display("FAIL rst_drain_cycles: got %0d expected 0", run_cycles); end
        rst = 1'b0;
        instr = NOP_I;
    endtask

    task automatic test_saturation();
        do_reset();
        send(3'd1, 16'd0);
        repeat (20) tick();
        checks++; if (s_run_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", s_run_cycles); end
        checks++; if (run_cycles !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d expected 20", run_cycles); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_step3();
        test_step0();
        test_halt_detect();
        test_prst_from_done();
        test_host_halt();
        test_priority();
        test_cmd_misc();
        test_rst_in_drain();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Sequences the MIPS pipeline in debug mode by generating the global pipeline enable (fetch `i_debug_enb` and the latch-enables of downstream stages) and a pipeline reset pulse.
- Commands arrive from the SPI debug unit: run, N-step, halt, pipeline reset.
- Detects the HALT opcode at the IF/ID instruction output, drains the remaining pipeline stages, then freezes.
- Counts enabled cycles for host readback.

Parameters:
- NB_BITS, 32, instruction width.
- NB_STEP, 16, width of step-count operand.
- NB_CYC, 32, width of run-cycle counter.
- DRAIN_CYCLES, 4, enabled cycles after HALT detection (ID, EX, MEM, WB complete).
- PRST_CYCLES, 2, length of pipeline reset pulse.
- HALT_INSTR, 32'hFFFF_FFFF, halt opcode.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_cmd_valid  in  1  command strobe from SPI debug unit
- i_cmd  in  3  0=NOP, 1=RUN, 2=STEP, 3=HALT, 4=PRST; others are NOP
- i_step_count  in  NB_STEP  step count, sampled with a STEP command
- i_if_id_instr  in  NB_BITS  current IF/ID instruction output
- o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready
- o_debug_enb  out  1  pipeline enable (registered)
- o_pipe_rst  out  1  pipeline reset pulse (registered)
- o_halted  out  1  high in DONE
- o_state  out  3  current state encoding, for SPI readback
- o_run_cycles  out  NB_CYC  enabled-cycle counter, saturating

Behaviour:
- Reset values: state IDLE, o_debug_enb=0, o_pipe_rst=0, o_halted=0, o_run_cycles=0, internal counters=0. o_cmd_ready is combinational from state, so it reads 1 in IDLE.
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4, PRST=5.
- o_cmd_ready is 1 in IDLE, RUN and DONE; 0 in STEP, DRAIN and PRST.
- Latency: a command accepted at edge N raises o_debug_enb from cycle N+1.
- IDLE and DONE commands:
  - RUN -> RUN.
  - STEP -> STEP; load step_cnt = i_step_count, with 0 treated as 1.
  - PRST -> PRST.
  - HALT and NOP -> no effect.
  - Leaving DONE clears o_halted.
- RUN:
  - o_debug_enb=1 every cycle.
  - An accepted HALT command -> IDLE; o_debug_enb=0 from the next cycle, with no drain (whole pipeline frozen coherently).
  - Other commands are accepted and dropped.
- STEP:
  - o_debug_enb=1 for exactly step_cnt cycles, then IDLE.
  - Counter decrements on each enabled edge; the transition fires on the edge where step_cnt==1.
- HALT detection applies in RUN and STEP:
  - Trigger: an edge where o_debug_enb==1 and i_if_id_instr==HALT_INSTR.
  - Action: -> DRAIN, load drain_cnt=DRAIN_CYCLES.
  - Priority: HALT detection beats the step counter expiring and beats a host HALT command on the same edge.
- DRAIN: o_debug_enb=1 for exactly DRAIN_CYCLES further cycles, then DONE with o_debug_enb=0 and o_halted=1.
- DONE: pipeline frozen; leaves only on an accepted command.
  - RUN after DONE re-enables; the HALT opcode is still at IF/ID, so re-detection is expected and correct.
- PRST:
  - o_pipe_rst=1 and o_debug_enb=0 for PRST_CYCLES cycles, then IDLE.
  - o_run_cycles cleared on entry.
- o_run_cycles: +1 on every edge with o_debug_enb==1; saturates at all-ones, no wrap.
- i_rst at any time, including mid-DRAIN or mid-PRST: immediate return to reset values; o_pipe_rst is not asserted by i_rst itself.
- Unknown i_cmd values are treated as NOP and accepted.

Decomposition:
- Shared include/package:
  - Command codes CMD_NOP/RUN/STEP/HALT/PRST.
  - State encodings ST_IDLE..ST_PRST.
  - HALT_INSTR constant, shared with the assembler and the debug SPI unit.
- One sub-module, `sat_counter` (parameterised width, enable, sync clear, saturate), instantiated for o_run_cycles.
- step_cnt and drain_cnt are plain down-counters inside the FSM.

Test Plan:
- Reset then idle 10 cycles -> o_debug_enb=0, o_state=0, o_cmd_ready=1, o_run_cycles=0.
- STEP with i_step_count=3, instr=NOP -> o_debug_enb high exactly 3 cycles starting the cycle after accept; o_state=0 afterwards; o_run_cycles=3.
- STEP with i_step_count=0 -> exactly 1 enabled cycle.
- RUN, then drive i_if_id_instr=32'hFFFF_FFFF on the 6th enabled edge -> DRAIN with 4 more enable cycles, then o_halted=1, o_state=4, o_run_cycles=10.
- RUN for 5 cycles, then host HALT -> o_debug_enb=0 next cycle, o_state=0, o_halted=0; a following STEP 2 adds exactly 2 cycles.
- PRST from DONE -> o_pipe_rst high 2 cycles with o_debug_enb=0, o_run_cycles=0, o_halted=0, then IDLE.
- i_rst asserted during DRAIN -> next cycle all outputs at reset values.
- Saturation: with NB_CYC=4, RUN for 20 cycles -> o_run_cycles holds 15.
